ram_read_port_arbiter: RTL and testbench



---
 rtl/ram_read_port_arbiter.sv | 96 +++++++++
 tb/tb_ram_read_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_port_arbiter.sv
// rtl/ram_read_port_arbiter.sv - two-requester arbiter for one block-RAM read port with tagged 2-entry response FIFO
// Optional: RAM_ARB_FIXED_PRIO_EN selects fixed A-over-B priority instead of round-robin.
module ram_read_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              a_req_valid_i,
  output logic              a_req_ready_o,
  input  logic [ADDR_W-1:0] a_req_addr_i,
  input  logic              b_req_valid_i,
  output logic              b_req_ready_o,
  input  logic [ADDR_W-1:0] b_req_addr_i,
  output logic              ram_re_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [DATA_W-1:0] ram_rddata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o
);

  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, rd_ptr_q;
  logic [DATA_W:0] mem_q [2];
  logic [DATA_W:0] head;
  logic            inflight_q, tag_q;
  logic            push, pop, issue_ok, gnt, gnt_id;
  logic [2:0]      occ;

  assign push = inflight_q;
  assign pop  = (count_q != 2'd0) & rsp_ready_i;
  // Slots already committed (queued or returning next edge) after this cycle's pop.
  assign occ      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue_ok = rst_n_i & (occ < 3'd2);

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign gnt_id = ~a_req_valid_i;
`else
  logic last_q;
  assign gnt_id = (a_req_valid_i & b_req_valid_i) ? ~last_q : b_req_valid_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= 1'b1;
    end else if (gnt) begin
      last_q <= gnt_id;
    end
  end
`endif

  assign gnt           = issue_ok & (a_req_valid_i | b_req_valid_i);
  assign a_req_ready_o = gnt & ~gnt_id;
  assign b_req_ready_o = gnt & gnt_id;
  assign ram_re_o      = gnt;
  assign ram_addr_o    = gnt ? (gnt_id ? b_req_addr_i : a_req_addr_i) : '0;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      inflight_q <= gnt;
      if (gnt) tag_q <= gnt_id;
      if (push) begin
        mem_q[wr_ptr_q] <= {tag_q, ram_rddata_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Head is masked when empty so the response channel idles at zero.
  assign head        = mem_q[rd_ptr_q];
  assign rsp_valid_o = (count_q != 2'd0);
  assign rsp_id_o    = rsp_valid_o & head[DATA_W];
  assign rsp_data_o  = rsp_valid_o ? head[DATA_W-1:0] : '0;
  assign busy_o      = inflight_q | (count_q != 2'd0);

endmodule

// File: tb/tb_ram_read_port_arbiter.sv
// tb/tb_ram_read_port_arbiter.sv - scoreboard bench for ram_read_port_arbiter
module tb_ram_read_port_arbiter;

  logic        clk, rst_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [15:0] a_addr, b_addr, ram_addr;
  logic        ram_re;
  logic [19:0] ram_rddata;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [19:0] rsp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic m_last;
  logic [20:0] sb[$];

  ram_read_port_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_req_valid_i(a_valid), .a_req_ready_o(a_ready), .a_req_addr_i(a_addr),
    .b_req_valid_i(b_valid), .b_req_ready_o(b_ready), .b_req_addr_i(b_addr),
    .ram_re_o(ram_re), .ram_addr_o(ram_addr), .ram_rddata_i(ram_rddata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [19:0] rd_of(input logic [15:0] a);
    if (a == 16'h0010) return 20'h0ABCD;
    return {~a[3:0], a};
  endfunction

  // RAM port model: one-cycle read latency
  always @(posedge clk) ram_rddata <= ram_re ? rd_of(ram_addr) : 20'h5A5A5;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dut.inflight_q && dut.count_q == 2'd2) begin
        errors++;
        $display("FAIL overflow: push into full fifo at %0t", $time);
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got id=%b data=%h, want no response", rsp_id, rsp_data);
        end else begin
          logic [20:0] exp;
          exp = sb.pop_front();
          if ({rsp_id, rsp_data} !== exp) begin
            errors++;
            $display("FAIL sb_order: got id=%b data=%h, want id=%b data=%h", rsp_id, rsp_data, exp[20], exp[19:0]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_addr = 16'h1234; b_addr = 16'h5678;
    rsp_ready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks += 4;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_busy: got valid=%b busy=%b, want 0 0", rsp_valid, busy);
    end
    if (rsp_id !== 1'b0 || rsp_data !== 20'h0) begin
      errors++; $display("FAIL reset_rsp_payload: got id=%b data=%h, want 0 00000", rsp_id, rsp_data);
    end
    if (ram_re !== 1'b0 || ram_addr !== 16'h0) begin
      errors++; $display("FAIL reset_ram: got re=%b addr=%h, want 0 0000", ram_re, ram_addr);
    end
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got a=%b b=%b, want 0 0", a_ready, b_ready);
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    m_last = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0 || ram_re !== 1'b1 || ram_addr !== 16'h0010) begin
      errors++; $display("FAIL single_grant: got a=%b b=%b re=%b addr=%h, want 1 0 1 0010", a_ready, b_ready, ram_re, ram_addr);
    end
    sb.push_back({1'b0, 20'h0ABCD});
    m_last = 1'b0;
    next_cycle();
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_cycle1: got valid=%b busy=%b, want 0 1", rsp_valid, busy);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 20'h0ABCD) begin
      errors++; $display("FAIL single_rsp: got valid=%b id=%b data=%h, want 1 0 0abcd", rsp_valid, rsp_id, rsp_data);
    end
    idle(3);
  endtask

  task automatic test_alternate();
    logic ids[8];
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a_valid = (k < 8); b_valid = (k < 8);
      a_addr = 16'h1000 + 16'(k); b_addr = 16'h2000 + 16'(k);
      @(negedge clk);
      if (k < 8) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        ids[k] = 1'b0;
`else
        ids[k] = ~m_last;
`endif
        checks++;
        if (a_ready !== ~ids[k] || b_ready !== ids[k] || ram_addr !== (ids[k] ? b_addr : a_addr)) begin
          errors++; $display("FAIL alt_grant%0d: got a=%b b=%b addr=%h, want id %b", k, a_ready, b_ready, ram_addr, ids[k]);
        end
        sb.push_back({ids[k], rd_of(ids[k] ? b_addr : a_addr)});
        m_last = ids[k];
      end
      if (k >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== ids[k-2]) begin
          errors++; $display("FAIL alt_rsp%0d: got valid=%b id=%b, want 1 %b", k, rsp_valid, rsp_id, ids[k-2]);
        end
      end
      next_cycle();
    end
    idle(3);
  endtask

  task automatic test_backpressure(input logic id);
    rsp_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      rsp_ready = (k >= 5);
      a_valid = (k < 8) && !id; b_valid = (k < 8) && id;
      a_addr = 16'h3000 + 16'(k); b_addr = 16'h4000 + 16'(k);
      @(negedge clk);
      if (k < 8) begin
        logic exp_g;
        exp_g = (k < 2) || (k >= 5);
        checks++;
        if (a_ready !== (exp_g & ~id) || b_ready !== (exp_g & id)) begin
          errors++; $display("FAIL bp%0d_grant%0d: got a=%b b=%b, want grant=%b", id, k, a_ready, b_ready, exp_g);
        end
        if (exp_g) begin
          sb.push_back({id, rd_of(id ? b_addr : a_addr)});
          m_last = id;
        end
      end
      if (k == 4) begin
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b1 || rsp_id !== id || rsp_data !== rd_of(id ? 16'h4000 : 16'h3000)) begin
          errors++; $display("FAIL bp%0d_full: got busy=%b valid=%b id=%b data=%h, want 1 1 %b %h", id, busy, rsp_valid, rsp_id, rsp_data, id, rd_of(id ? 16'h4000 : 16'h3000));
        end
      end
      next_cycle();
    end
    rsp_ready = 1'b1;
    idle(4);
  endtask

  task automatic test_reset_midread();
    rsp_ready = 1'b1;
    a_valid = 1'b1; a_addr = 16'h0777;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL rst_pre_grant: got a=%b, want 1", a_ready);
    end
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || ram_re !== 1'b0) begin
      errors++; $display("FAIL rst_async: got valid=%b busy=%b re=%b, want 0 0 0", rsp_valid, busy, ram_re);
    end
    a_valid = 1'b0;
    sb.delete();
    next_cycle();
    rst_n = 1'b1;
    m_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_ghost%0d: got valid=%b busy=%b, want 0 0", k, rsp_valid, busy);
      end
      next_cycle();
    end
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 16'h0123; b_addr = 16'h0456;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL rst_first_tie: got a=%b b=%b, want 1 0", a_ready, b_ready);
    end
    sb.push_back({1'b0, rd_of(16'h0123)});
    m_last = 1'b0;
    next_cycle();
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs[2];
    addrs[0] = 16'hFFFF; addrs[1] = 16'h0000;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_valid = (k < 2);
      if (k < 2) b_addr = addrs[k];
      @(negedge clk);
      if (k < 2) begin
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0 || ram_addr !== addrs[k]) begin
          errors++; $display("FAIL b2b_grant%0d: got b=%b a=%b addr=%h, want 1 0 %h", k, b_ready, a_ready, ram_addr, addrs[k]);
        end
        sb.push_back({1'b1, rd_of(addrs[k])});
      end else begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== rd_of(addrs[k-2])) begin
          errors++; $display("FAIL b2b_rsp%0d: got valid=%b id=%b data=%h, want 1 1 %h", k, rsp_valid, rsp_id, rsp_data, rd_of(addrs[k-2]));
        end
      end
      next_cycle();
    end
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; rsp_ready = 1'b0; m_last = 1'b1;
    #1;
    test_reset();
    test_single_a();
    test_alternate();
    test_backpressure(1'b0);
    test_backpressure(1'b1);
    test_reset_midread();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d outstanding, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
